apb_fll_cfg_bridge: RTL and testbench

APB slave that converts register accesses into the four-phase req/ack configuration handshake of the three clock generators: SoC, peripheral and cluster. It drives the `*_fll_slave_*` configuration inputs of the clock/reset generation block and returns read data and lock status to the SoC bus. It runs on the SoC clock. FLL ack and lock inputs are treated as asynchronous and synchronised internally.

---
 rtl/fll_cfg_pkg.sv | 34 +++
 rtl/fll_cfg_sync.sv | 23 ++
 rtl/apb_fll_cfg_bridge.sv | 161 ++++++++++++++++
 tb/tb_apb_fll_cfg_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the APB to FLL configuration bridge.
package fll_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REQ,
        ST_REL,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] FLL_SOC     = 2'd0;
    localparam logic [1:0] FLL_PER     = 2'd1;
    localparam logic [1:0] FLL_CLUSTER = 2'd2;
    localparam logic [1:0] FLL_STATUS  = 2'd3;

    // Address field positions: [5:4] picks the FLL, [3:2] the register in it.
    localparam int FLL_SEL_LSB = 4;
    localparam int REG_SEL_LSB = 2;

    function automatic logic [2:0] fll_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            FLL_SOC:     oh = 3'b001;
            FLL_PER:     oh = 3'b010;
            FLL_CLUSTER: oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// Two-flop synchroniser for asynchronous FLL ack/lock levels.
module fll_cfg_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/apb_fll_cfg_bridge.sv
// APB slave turning register accesses into the four-phase req/ack
// configuration handshake of the SoC, peripheral and cluster FLLs.
module apb_fll_cfg_bridge
    import fll_cfg_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [2:0]                fll_req_o,
    output logic                      fll_wrn_o,
    output logic [1:0]                fll_add_o,
    output logic [31:0]               fll_data_o,
    input  logic [2:0]                fll_ack_i,
    input  logic [2:0][31:0]          fll_r_data_i,
    input  logic [2:0]                fll_lock_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic [2:0]       ack_s;
    logic [2:0]       lock_s;
    logic [3:0]       ack_x;
    logic [1:0]       sel;
    logic [1:0]       reg_sel;
    logic             access;
    logic             status_acc;
    logic [31:0]      r_sel;
    logic             unused_addr;

    fll_cfg_sync #(.WIDTH(3)) u_ack_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (fll_ack_i),
        .q     (ack_s)
    );

    fll_cfg_sync #(.WIDTH(3)) u_lock_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (fll_lock_i),
        .q     (lock_s)
    );

    assign sel         = paddr_i[FLL_SEL_LSB +: 2];
    assign reg_sel     = paddr_i[REG_SEL_LSB +: 2];
    assign access      = psel_i & penable_i;
    assign status_acc  = access && (sel == FLL_STATUS);
    // Padding with a constant 0 lets the status index never match an ack.
    assign ack_x       = {1'b0, ack_s};
    assign unused_addr = ^{paddr_i[APB_ADDR_WIDTH-1:6], paddr_i[1:0]};

    always_comb begin
        r_sel = '0;
        case (idx)
            FLL_SOC:     r_sel = fll_r_data_i[0];
            FLL_PER:     r_sel = fll_r_data_i[1];
            FLL_CLUSTER: r_sel = fll_r_data_i[2];
            default:     r_sel = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            fll_req_o  <= '0;
            fll_wrn_o  <= 1'b1;
            fll_add_o  <= '0;
            fll_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access && (sel != FLL_STATUS)) begin
                        idx        <= sel;
                        fll_add_o  <= reg_sel;
                        fll_data_o <= pwdata_i;
                        fll_wrn_o  <= ~pwrite_i;
                        cnt        <= '0;
                        if (ack_x[sel]) begin
                            state <= ST_DRAIN;
                        end else begin
                            state     <= ST_REQ;
                            fll_req_o <= fll_onehot(sel);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!ack_x[idx]) begin
                        state     <= ST_REQ;
                        fll_req_o <= fll_onehot(idx);
                        cnt       <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_ERR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    if (ack_x[idx]) begin
                        rdata_q   <= fll_wrn_o ? r_sel : 32'h0;
                        fll_req_o <= '0;
                        state     <= ST_REL;
                        cnt       <= '0;
                    end else if (cnt == CNT_LAST) begin
                        fll_req_o <= '0;
                        state     <= ST_ERR;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_REL: begin
                    if (!ack_x[idx]) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_ERR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        prdata_o = '0;
        if (state == ST_DONE) begin
            prdata_o = rdata_q;
        end else if ((state == ST_IDLE) && status_acc && !pwrite_i) begin
            prdata_o = {29'b0, lock_s};
        end
    end

    assign pready_o  = (state == ST_DONE) || (state == ST_ERR) ||
                       ((state == ST_IDLE) && status_acc);
    assign pslverr_o = (state == ST_ERR);

endmodule

// File: tb/tb_apb_fll_cfg_bridge.sv
// Self-checking bench for apb_fll_cfg_bridge with a same-clock FLL model.
module tb_apb_fll_cfg_bridge;

    localparam int TIMEOUT = 8;
    localparam int REF_LAT = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [11:0]      paddr = '0;
    logic [31:0]      pwdata = '0;
    logic             pwrite = 1'b0;
    logic             psel = 1'b0;
    logic             penable = 1'b0;
    logic [31:0]      prdata;
    logic             pready;
    logic             pslverr;
    logic [2:0]       fll_req;
    logic             fll_wrn;
    logic [1:0]       fll_add;
    logic [31:0]      fll_data;
    logic [2:0]       fll_ack = 3'b000;
    logic [2:0][31:0] fll_r_data;
    logic [2:0]       fll_lock = 3'b000;

    int checks = 0;
    int failures = 0;

    apb_fll_cfg_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pwrite_i     (pwrite),
        .psel_i       (psel),
        .penable_i    (penable),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .fll_req_o    (fll_req),
        .fll_wrn_o    (fll_wrn),
        .fll_add_o    (fll_add),
        .fll_data_o   (fll_data),
        .fll_ack_i    (fll_ack),
        .fll_r_data_i (fll_r_data),
        .fll_lock_i   (fll_lock)
    );

    always #5 clk = ~clk;

    // FLL model: mode 0 registers ack<=req, 1 never acks, 2 holds ack high.
    logic [31:0] fll_mem [3][4] = '{default: '0};
    int          mode [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (mode[n] == 1)      fll_ack[n] <= 1'b0;
            else if (mode[n] == 2) fll_ack[n] <= 1'b1;
            else                   fll_ack[n] <= fll_req[n];
            if (mode[n] == 0 && fll_req[n] && !fll_ack[n] && !fll_wrn)
                fll_mem[n][fll_add] <= fll_data;
        end
    end

    always_comb begin
        for (int n = 0; n < 3; n++)
            fll_r_data[n] = fll_ack[n] ? fll_mem[n][fll_add] : 32'h0;
    end

    // Reference register contents, updated only by completed bench writes.
    logic [31:0] ref_mem [3][4] = '{default: '0};

    int         req_rise [3] = '{0, 0, 0};
    int         req_high [3] = '{0, 0, 0};
    int         overlap_cnt = 0;
    logic [2:0] req_prev = 3'b000;

    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (fll_req[n]) req_high[n]++;
            if (fll_req[n] && !req_prev[n]) req_rise[n]++;
        end
        if ($countones(fll_req) > 1) overlap_cnt++;
        req_prev = fll_req;
    end

    task automatic apb_access(input logic [11:0] addr, input logic [31:0] wdata,
                              input logic wr, output logic [31:0] rdata,
                              output logic err, output int ws,
                              output logic [2:0] req1, output logic [1:0] add1,
                              output logic wrn1, output logic [31:0] data1);
        @(negedge clk);
        paddr = addr; pwdata = wdata; pwrite = wr; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        ws = 0; req1 = '0; add1 = '0; wrn1 = 1'b1; data1 = '0;
        while (!pready && ws < 40) begin
            @(negedge clk);
            #1;
            ws++;
            if (ws == 1) begin
                req1 = fll_req; add1 = fll_add; wrn1 = fll_wrn; data1 = fll_data;
            end
        end
        checks++;
        if (!pready) begin
            failures++;
            $display("FAIL apb_complete: pready=%0b after %0d cycles, required 1", pready, ws);
        end
        rdata = prdata;
        err = pslverr;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks += 7;
        if (fll_req !== 3'b000) begin failures++; $display("FAIL rst_req: got %b want 000", fll_req); end
        if (fll_wrn !== 1'b1) begin failures++; $display("FAIL rst_wrn: got %b want 1", fll_wrn); end
        if (fll_add !== 2'd0) begin failures++; $display("FAIL rst_add: got %0d want 0", fll_add); end
        if (fll_data !== 32'h0) begin failures++; $display("FAIL rst_data: got %h want 0", fll_data); end
        if (prdata !== 32'h0) begin failures++; $display("FAIL rst_prdata: got %h want 0", prdata); end
        if (pready !== 1'b0) begin failures++; $display("FAIL rst_pready: got %b want 0", pready); end
        if (pslverr !== 1'b0) begin failures++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_per_write();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        apb_access(12'h018, 32'hDEAD_BEEF, 1'b1, rd, err, ws, r1, a1, w1, d1);
        ref_mem[1][2] = 32'hDEAD_BEEF;
        checks += 6;
        if (r1 !== 3'b010) begin failures++; $display("FAIL per_wr_req: got %b want 010", r1); end
        if (a1 !== 2'd2) begin failures++; $display("FAIL per_wr_add: got %0d want 2", a1); end
        if (w1 !== 1'b0) begin failures++; $display("FAIL per_wr_wrn: got %b want 0", w1); end
        if (d1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL per_wr_data: got %h want deadbeef", d1); end
        if (ws != REF_LAT) begin failures++; $display("FAIL per_wr_lat: got %0d want %0d", ws, REF_LAT); end
        if (err !== 1'b0) begin failures++; $display("FAIL per_wr_err: got %b want 0", err); end
    endtask

    task automatic test_cluster_read();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        int rise0 [3];
        apb_access(12'h024, 32'h1234_5678, 1'b1, rd, err, ws, r1, a1, w1, d1);
        ref_mem[2][1] = 32'h1234_5678;
        for (int n = 0; n < 3; n++) rise0[n] = req_rise[n];
        apb_access(12'h024, 32'h0, 1'b0, rd, err, ws, r1, a1, w1, d1);
        checks += 5;
        if (rd !== 32'h1234_5678) begin failures++; $display("FAIL cl_rd_data: got %h want 12345678", rd); end
        if (req_rise[2] - rise0[2] != 1) begin failures++; $display("FAIL cl_rd_rise2: got %0d want 1", req_rise[2] - rise0[2]); end
        if ((req_rise[0] - rise0[0]) + (req_rise[1] - rise0[1]) != 0) begin
            failures++; $display("FAIL cl_rd_other_req: got %0d rises want 0", (req_rise[0] - rise0[0]) + (req_rise[1] - rise0[1]));
        end
        if (w1 !== 1'b1) begin failures++; $display("FAIL cl_rd_wrn: got %b want 1", w1); end
        if (ws != REF_LAT) begin failures++; $display("FAIL cl_rd_lat: got %0d want %0d", ws, REF_LAT); end
    endtask

    task automatic test_status();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        int rise_sum;
        @(negedge clk);
        fll_lock = 3'b101;
        repeat (2) @(negedge clk);
        rise_sum = req_rise[0] + req_rise[1] + req_rise[2];
        apb_access(12'h030, 32'h0, 1'b0, rd, err, ws, r1, a1, w1, d1);
        checks += 4;
        if (rd !== 32'h5) begin failures++; $display("FAIL st_rd_data: got %h want 5", rd); end
        if (ws != 0) begin failures++; $display("FAIL st_rd_lat: got %0d want 0", ws); end
        if (err !== 1'b0) begin failures++; $display("FAIL st_rd_err: got %b want 0", err); end
        if (req_rise[0] + req_rise[1] + req_rise[2] != rise_sum) begin failures++; $display("FAIL st_rd_noreq: req rose during status read"); end
        apb_access(12'h03C, 32'hFFFF_FFFF, 1'b1, rd, err, ws, r1, a1, w1, d1);
        checks += 2;
        if (ws != 0) begin failures++; $display("FAIL st_wr_lat: got %0d want 0", ws); end
        if (err !== 1'b0) begin failures++; $display("FAIL st_wr_err: got %b want 0", err); end
    endtask

    task automatic test_timeout_drain();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        int high0;
        int rise0;
        mode[0] = 1;
        high0 = req_high[0];
        apb_access(12'h008, 32'hA5A5_0001, 1'b1, rd, err, ws, r1, a1, w1, d1);
        checks += 4;
        if (err !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", err); end
        if (ws != REF_LAT) begin failures++; $display("FAIL to_lat: got %0d want %0d", ws, REF_LAT); end
        if (rd !== 32'h0) begin failures++; $display("FAIL to_prdata: got %h want 0", rd); end
        if (req_high[0] - high0 != TIMEOUT) begin failures++; $display("FAIL to_req_cycles: got %0d want %0d", req_high[0] - high0, TIMEOUT); end

        mode[0] = 2;
        repeat (3) @(negedge clk);
        rise0 = req_rise[0];
        fork
            apb_access(12'h008, 32'h0, 1'b0, rd, err, ws, r1, a1, w1, d1);
            begin
                repeat (6) @(negedge clk);
                #1;
                checks += 2;
                if (req_rise[0] != rise0) begin failures++; $display("FAIL drain_req: req rose while ack stuck"); end
                if (pready !== 1'b0) begin failures++; $display("FAIL drain_pready: got %b want 0", pready); end
                mode[0] = 0;
            end
        join
        // Ack released in C4; it takes one model cycle plus two sync stages
        // before the request launches, then a normal transfer follows.
        checks += 3;
        if (ws != 4 + 3 + REF_LAT) begin failures++; $display("FAIL drain_lat: got %0d want %0d", ws, 4 + 3 + REF_LAT); end
        if (err !== 1'b0) begin failures++; $display("FAIL drain_err: got %b want 0", err); end
        if (rd !== ref_mem[0][2]) begin failures++; $display("FAIL drain_data: got %h want %h", rd, ref_mem[0][2]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        @(negedge clk);
        paddr = 12'h014; pwdata = 32'h0; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (fll_req !== 3'b010) begin failures++; $display("FAIL rm_inreq: got %b want 010", fll_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (fll_req !== 3'b000) begin failures++; $display("FAIL rm_req: got %b want 000", fll_req); end
        if (fll_wrn !== 1'b1) begin failures++; $display("FAIL rm_wrn: got %b want 1", fll_wrn); end
        if (fll_add !== 2'd0) begin failures++; $display("FAIL rm_add: got %0d want 0", fll_add); end
        if (fll_data !== 32'h0) begin failures++; $display("FAIL rm_data: got %h want 0", fll_data); end
        if (prdata !== 32'h0) begin failures++; $display("FAIL rm_prdata: got %h want 0", prdata); end
        if (pready !== 1'b0) begin failures++; $display("FAIL rm_pready: got %b want 0", pready); end
        if (pslverr !== 1'b0) begin failures++; $display("FAIL rm_pslverr: got %b want 0", pslverr); end
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        apb_access(12'h018, 32'h0, 1'b0, rd, err, ws, r1, a1, w1, d1);
        checks += 3;
        if (ws != REF_LAT) begin failures++; $display("FAIL rm_after_lat: got %0d want %0d", ws, REF_LAT); end
        if (err !== 1'b0) begin failures++; $display("FAIL rm_after_err: got %b want 0", err); end
        if (rd !== ref_mem[1][2]) begin failures++; $display("FAIL rm_after_data: got %h want %h", rd, ref_mem[1][2]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        int ws_a;
        int ov0;
        int rise0 [3];
        ov0 = overlap_cnt;
        for (int n = 0; n < 3; n++) rise0[n] = req_rise[n];
        apb_access(12'h00C, 32'hCAFE_F00D, 1'b1, rd, err, ws_a, r1, a1, w1, d1);
        ref_mem[0][3] = 32'hCAFE_F00D;
        apb_access(12'h018, 32'h0, 1'b0, rd, err, ws, r1, a1, w1, d1);
        checks += 6;
        if (ws_a != REF_LAT) begin failures++; $display("FAIL b2b_lat_wr: got %0d want %0d", ws_a, REF_LAT); end
        if (ws != REF_LAT) begin failures++; $display("FAIL b2b_lat_rd: got %0d want %0d", ws, REF_LAT); end
        if (rd !== ref_mem[1][2]) begin failures++; $display("FAIL b2b_rd_data: got %h want %h", rd, ref_mem[1][2]); end
        if (overlap_cnt != ov0) begin failures++; $display("FAIL b2b_overlap: got %0d overlaps want 0", overlap_cnt - ov0); end
        if (req_rise[0] - rise0[0] != 1) begin failures++; $display("FAIL b2b_rise_soc: got %0d want 1", req_rise[0] - rise0[0]); end
        if (req_rise[1] - rise0[1] != 1) begin failures++; $display("FAIL b2b_rise_per: got %0d want 1", req_rise[1] - rise0[1]); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic err; int ws; logic [2:0] r1; logic [1:0] a1; logic w1; logic [31:0] d1;
        for (int i = 0; i < 24; i++) begin
            int s;
            int r;
            logic wr;
            logic [31:0] wd;
            logic [11:0] addr;
            s = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            addr = 12'((s << 4) | (r << 2));
            if (s == 3) begin
                @(negedge clk);
                fll_lock = 3'($urandom_range(0, 7));
                repeat (2) @(negedge clk);
                apb_access(addr, wd, wr, rd, err, ws, r1, a1, w1, d1);
                checks += 2;
                if (ws != 0) begin failures++; $display("FAIL rnd_st_lat[%0d]: got %0d want 0", i, ws); end
                if (rd !== (wr ? 32'h0 : {29'b0, fll_lock})) begin
                    failures++; $display("FAIL rnd_st_data[%0d]: got %h want %h", i, rd, wr ? 32'h0 : {29'b0, fll_lock});
                end
            end else begin
                apb_access(addr, wd, wr, rd, err, ws, r1, a1, w1, d1);
                checks += 6;
                if (ws != REF_LAT) begin failures++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, ws, REF_LAT); end
                if (err !== 1'b0) begin failures++; $display("FAIL rnd_err[%0d]: got %b want 0", i, err); end
                if (r1 !== 3'(1 << s)) begin failures++; $display("FAIL rnd_req[%0d]: got %b want %b", i, r1, 3'(1 << s)); end
                if (a1 !== 2'(r)) begin failures++; $display("FAIL rnd_add[%0d]: got %0d want %0d", i, a1, r); end
                if (w1 !== !wr || d1 !== wd) begin
                    failures++; $display("FAIL rnd_cmd[%0d]: wrn %b data %h want %b %h", i, w1, d1, !wr, wd);
                end
                if (rd !== (wr ? 32'h0 : ref_mem[s][r])) begin
                    failures++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rd, wr ? 32'h0 : ref_mem[s][r]);
                end
                if (wr) ref_mem[s][r] = wd;
            end
        end
    endtask

    initial begin
        test_reset();
        test_per_write();
        test_cluster_read();
        test_status();
        test_timeout_drain();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (overlap_cnt != 0) begin failures++; $display("FAIL req_onehot: %0d cycles with several req bits", overlap_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
